// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Pipelined W-bit add/sub (ADD/SUB/ADC/SBC), one carry segment per
//            stage, valid/ready handshake with global stall. Optional status
//            flags enabled by defining PIPELINED_ADDSUB_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
    parameter int W      = 64,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry,
    output logic         overflow,
    output logic         zero
);

    localparam int SW = W / STAGES;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;

    logic         w_adv;
    logic [W-1:0] w_b_prep;
    logic         w_c0;

    // op[0] selects subtraction (invert b); op[1] selects the external carry.
    always_comb begin
        w_b_prep = op[0] ? ~b : b;
        case (op)
            c_op_add: w_c0 = 1'b0;
            c_op_sub: w_c0 = 1'b1;
            default:  w_c0 = cin;
        endcase
    end

    // Whole pipe moves together; in_ready follows out_ready combinationally.
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Beat layout entering stage gi: {a_rem, b_rem, sum_lo}, where a_rem and
    // b_rem hold the unprocessed segments gi..STAGES-1 and sum_lo the finished
    // segments 0..gi-1. a_rem therefore always starts at bit W and the current
    // b' segment sits at bit gi*SW.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int DW_IN  = 2*W - gi*SW;
            localparam int DW_OUT = DW_IN - SW;

            logic [DW_IN-1:0]  w_in;
            logic              w_c_in;
            logic              w_v_in;
            logic [SW:0]       w_seg;
            logic [DW_OUT-1:0] w_next;
            logic [DW_OUT-1:0] r_data;
            logic              r_carry;
            logic              r_valid;

            if (gi == 0) begin : g_first
                assign w_in   = {a, w_b_prep};
                assign w_c_in = w_c0;
                assign w_v_in = in_valid;
            end else begin : g_chain
                assign w_in   = g_stage[gi-1].r_data;
                assign w_c_in = g_stage[gi-1].r_carry;
                assign w_v_in = g_stage[gi-1].r_valid;
            end

            assign w_seg = {1'b0, w_in[W +: SW]} + {1'b0, w_in[gi*SW +: SW]}
                         + {{SW{1'b0}}, w_c_in};

            if (gi == STAGES-1) begin : g_last
                if (gi == 0) begin : g_only
                    assign w_next = w_seg[SW-1:0];
                end else begin : g_merge
                    assign w_next = {w_seg[SW-1:0], w_in[gi*SW-1:0]};
                end

                assign out_valid = r_valid;
                assign sum       = r_data;
                assign carry     = r_carry;

`ifdef PIPELINED_ADDSUB_FLAGS_EN
                logic w_ovf_next;
                logic w_zero_next;
                logic r_overflow;
                logic r_zero;

                // Operand MSBs are the top bits of the last a/b' segments.
                assign w_ovf_next  = (w_in[DW_IN-1] == w_in[W-1])
                                   & (w_seg[SW-1] != w_in[DW_IN-1]);
                assign w_zero_next = (w_next == '0);

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_overflow <= 1'b0;
                        r_zero     <= 1'b0;
                    end else if (w_adv) begin
                        r_overflow <= w_ovf_next;
                        r_zero     <= w_zero_next;
                    end
                end

                assign overflow = r_overflow;
                assign zero     = r_zero;
`else
                assign overflow = 1'b0;
                assign zero     = 1'b0;
`endif
            end else begin : g_mid
                if (gi == 0) begin : g_head
                    assign w_next = {w_in[DW_IN-1:W+SW], w_in[W-1:SW],
                                     w_seg[SW-1:0]};
                end else begin : g_body
                    assign w_next = {w_in[DW_IN-1:W+SW], w_in[W-1:(gi+1)*SW],
                                     w_seg[SW-1:0], w_in[gi*SW-1:0]};
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_data  <= '0;
                end else if (w_adv) begin
                    r_valid <= w_v_in;
                    r_carry <= w_seg[SW];
                    r_data  <= w_next;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Directed vector bench for pipelined_addsub (W=64/STAGES=4 and
//            W=8/STAGES=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

    localparam int W      = 64;
    localparam int STAGES = 4;
`ifdef PIPELINED_ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    localparam logic [1:0] c_add = 2'b00;
    localparam logic [1:0] c_sub = 2'b01;
    localparam logic [1:0] c_adc = 2'b10;
    localparam logic [1:0] c_sbc = 2'b11;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         overflow;
    logic         zero;

    logic         in_valid_s1;
    logic         in_ready_s1;
    logic [1:0]   op_s1;
    logic [7:0]   a_s1;
    logic [7:0]   b_s1;
    logic         cin_s1;
    logic         out_valid_s1;
    logic [7:0]   sum_s1;
    logic         carry_s1;
    logic         overflow_s1;
    logic         zero_s1;

    pipelined_addsub #(.W(W), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .zero(zero)
    );

    pipelined_addsub #(.W(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_s1), .in_ready(in_ready_s1),
        .op(op_s1), .a(a_s1), .b(b_s1), .cin(cin_s1),
        .out_valid(out_valid_s1), .out_ready(1'b1),
        .sum(sum_s1), .carry(carry_s1), .overflow(overflow_s1), .zero(zero_s1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        carry;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t        vecs[10];
    int          checks   = 0;
    int          failures = 0;
    logic        mv[STAGES];
    logic [63:0] md[STAGES];

    task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Issue one beat into an empty pipe and check it emerges exactly STAGES
    // clocks later. Called and returns at a negative clock edge.
    task automatic run_beat(input string name, input logic [1:0] t_op,
                            input logic [63:0] t_a, input logic [63:0] t_b,
                            input logic t_cin, input logic [63:0] e_sum,
                            input logic e_carry, input logic e_ovf, input logic e_zero);
        logic lat_ok;
        op = t_op; a = t_a; b = t_b; cin = t_cin; in_valid = 1'b1;
        #1;
        check_bit({name, " in_ready"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        a = ~t_a; b = ~t_b; cin = ~t_cin; op = ~t_op;
        lat_ok = 1'b1;
        for (int k = 0; k < STAGES-1; k++) begin
            if (out_valid !== 1'b0) lat_ok = 1'b0;
            @(negedge clk);
        end
        check_bit({name, " early out_valid clear"}, lat_ok, 1'b1);
        check_bit({name, " out_valid"}, out_valid, 1'b1);
        check_word({name, " sum"}, sum, e_sum);
        check_bit({name, " carry"}, carry, e_carry);
        check_bit({name, " overflow"}, overflow, FLAGS & e_ovf);
        check_bit({name, " zero"}, zero, FLAGS & e_zero);
    endtask

    task automatic run_s1(input string name, input logic [1:0] t_op, input logic [7:0] t_a,
                          input logic [7:0] t_b, input logic t_cin,
                          input logic [7:0] e_sum, input logic e_carry);
        op_s1 = t_op; a_s1 = t_a; b_s1 = t_b; cin_s1 = t_cin; in_valid_s1 = 1'b1;
        #1;
        check_bit({name, " in_ready"}, in_ready_s1, 1'b1);
        @(negedge clk);
        in_valid_s1 = 1'b0;
        a_s1 = 8'h5A; b_s1 = 8'hA5;
        check_bit({name, " out_valid"}, out_valid_s1, 1'b1);
        check_word({name, " sum"}, 64'(sum_s1), 64'(e_sum));
        check_bit({name, " carry"}, carry_s1, e_carry);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_adv;
        logic flushed;
        int   sent;
        int   got;

        vecs[0] = '{c_add, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{c_sub, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{c_sub, 64'd7, 64'd5, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{c_add, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{c_adc, 64'h0000_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{c_sbc, 64'd10, 64'd3, 1'b0, 64'd6, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{c_sbc, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{c_add, 64'd1, 64'd1, 1'b1, 64'd2, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{c_sub, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{c_adc, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; op = c_add; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        in_valid_s1 = 1'b0; op_s1 = c_add; a_s1 = '0; b_s1 = '0; cin_s1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("reset out_valid", out_valid, 1'b0);
        check_word("reset sum", sum, 64'd0);
        check_bit("reset carry", carry, 1'b0);
        check_bit("reset overflow", overflow, 1'b0);
        check_bit("reset zero", zero, 1'b0);
        check_bit("reset in_ready", in_ready, 1'b1);
        check_bit("reset s1 out_valid", out_valid_s1, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_beat($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                     vecs[i].sum, vecs[i].carry, vecs[i].ovf, vecs[i].zero);
        end

        // Back-to-back stream with a 3-cycle downstream stall, against a
        // reference model of the global-stall pipe.
        @(negedge clk);
        for (int s = 0; s < STAGES; s++) begin
            mv[s] = 1'b0;
            md[s] = '0;
        end
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            in_valid  = (sent < 8);
            op  = c_add;
            cin = 1'b1;
            a   = 64'(sent);
            b   = 64'(sent);
            #1;
            exp_adv = !mv[STAGES-1] || out_ready;
            check_bit($sformatf("stream c%0d in_ready", cyc), in_ready, exp_adv);
            check_bit($sformatf("stream c%0d out_valid", cyc), out_valid, mv[STAGES-1]);
            if (mv[STAGES-1]) begin
                check_word($sformatf("stream c%0d held sum", cyc), sum, md[STAGES-1]);
                if (out_ready) begin
                    check_word($sformatf("stream order %0d", got), sum, 64'(2*got));
                    got++;
                end
            end
            if (exp_adv) begin
                for (int s = STAGES-1; s > 0; s--) begin
                    mv[s] = mv[s-1];
                    md[s] = md[s-1];
                end
                mv[0] = in_valid;
                md[0] = a + b;
                if (in_valid) sent++;
            end
            @(negedge clk);
        end
        check_word("stream delivered count", 64'(got), 64'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            op = c_add;
            a  = 64'(100 + k);
            b  = 64'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("midreset out_valid", out_valid, 1'b0);
        check_word("midreset sum", sum, 64'd0);
        check_bit("midreset carry", carry, 1'b0);
        check_bit("midreset overflow", overflow, 1'b0);
        check_bit("midreset zero", zero, 1'b0);
        check_bit("midreset in_ready", in_ready, 1'b1);
        flushed = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) flushed = 1'b0;
        end
        check_bit("midreset beats discarded", flushed, 1'b1);
        run_beat("post-reset", c_add, 64'd40, 64'd2, 1'b0, 64'd42, 1'b0, 1'b0, 1'b0);

        run_s1("s1 sbc", c_sbc, 8'h10, 8'h01, 1'b0, 8'h0E, 1'b1);
        run_s1("s1 add wrap", c_add, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_s1("s1 sub borrow", c_sub, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined integer add/subtract unit that supersedes the single-cycle 64-bit add/sub wrapper. Operands are split into carry segments, one segment per pipeline stage, so the result sustains one operation per clock at a configurable latency. It adds add-with-carry and subtract-with-borrow modes, a valid/ready handshake with backpressure, and optional status flags. It sits between operand registers and the datapath result bus.

## Interface
- W, 64, operand/result width in bits.
- STAGES, 4, number of pipeline stages (carry segments); W % STAGES must be 0; segment width SW = W/STAGES.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset (sampled on rising edge of clk).
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- a, b  input  W  operands.
- cin  input  1  carry-in (ADC) / not-borrow (SBC); ignored for ADD/SUB.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  W  result.
- carry  output  1  carry-out (for SUB/SBC: 1 = no borrow).
- overflow  output  1  signed overflow (flags build only).
- zero  output  1  sum == 0 (flags build only).

## Operation
- Operand prep at input (combinational, before stage 0): b' = b for ADD/ADC, ~b for SUB/SBC; c0 = 0 ADD, 1 SUB, cin ADC/SBC.
- Arithmetic: {carry,sum} = a + b' + c0, modulo 2^W; SUB = a − b two's complement.
- Stage i (0..STAGES−1) adds segment i (bits [i*SW +: SW]) of a and b' plus the carry registered by stage i−1 (c0 for stage 0); registers the sum segment and segment carry-out.
- Lower completed sum segments and not-yet-processed upper a/b' segments are carried forward in pipeline registers with the beat; a[W−1] and b'[W−1] travel to the last stage for overflow.
- Each stage holds a valid bit; stage 0 captures in_valid.
- Global advance enable: adv = ~out_valid | out_ready; in_ready = adv. On adv all stages shift; otherwise all hold (no bubble collapsing).
- Beat accepted when in_valid & in_ready; beat delivered when out_valid & out_ready.
- Results emerge in acceptance order; no loss, no duplication.
- Invalid beats may shift data but never assert out_valid.
- STAGES = 1: single registered full-width adder, same handshake.

## Timing
- Reset (rst_n low at edge): all valid bits 0; sum, carry, overflow, zero = 0; in_ready = 1 the following cycle. Reset mid-operation discards all in-flight beats.
- Latency: beat accepted at edge N appears on outputs after edge N+STAGES−1 (outputs are stage STAGES−1 registers); i.e. STAGES clocks of latency.
- Throughput: 1 beat/clk while out_ready high.
- Stall: out_valid=1 & out_ready=0 → in_ready=0, all outputs stable until handshake.
- Simultaneous out handshake and new input: both occur, pipeline shifts.
- in_ready depends combinationally on out_ready (documented path; no skid buffer).
- op, cin, a, b sampled only on accepted beats.

## Configuration
- PIPELINED_ADDSUB_FLAGS_EN defined: overflow = (a[W−1] == b'[W−1]) & (sum[W−1] != a[W−1]); zero = (sum == 0); both registered with the final stage, valid with out_valid.
- Not defined: overflow and zero ports tied to 0; MSB tracking and zero-detect logic removed.

## Test plan
- W=64, STAGES=4, ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 → 4 clocks later sum=0, carry=1, zero=1, overflow=0.
- SUB a=5, b=7 → sum=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0; SUB a=7, b=5 → sum=2, carry=1.
- ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, overflow=1 (flags build), 0 (non-flags build); ADC a=0x0000_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0x0001_0000_0000_0000 (carry crosses three segment boundaries).
- 8 back-to-back beats (a=i, b=i, ADD), out_ready low for 3 cycles mid-stream → in_ready low exactly while out_valid&~out_ready, outputs held, sums 0,2,…,14 delivered in order, once each.
- 3 beats in flight, rst_n low one cycle → next cycle out_valid=0, all outputs 0, none of the 3 results ever appear; new beat after reset returns correct result at latency 4.
- STAGES=1, W=8: SBC a=0x10, b=0x01, cin=0 → next cycle sum=0x0E, carry=1.
